// File: rtl/debug_unit_dump_ctrl.sv
// Debug-unit state dump sequencer: streams status, PC, register file and the
// low data-memory words over the UART TX start/done handshake, MSB byte first.
module debug_unit_dump_ctrl #(
    parameter int N_BITS          = 8,
    parameter int N_BITS_INSTR    = 32,
    parameter int N_BITS_REG      = 5,
    parameter int N_REGS          = 32,
    parameter int N_BITS_MEM_ADDR = 5,
    parameter int N_MEM_WORDS     = 32,
    parameter int NB_STATE        = 3
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    input  logic                       i_dump_request,
    input  logic                       i_program_done,
    input  logic [N_BITS_INSTR-1:0]    i_pc,
    output logic [N_BITS_REG-1:0]      o_reg_addr,
    input  logic [N_BITS_INSTR-1:0]    i_reg_data,
    output logic [N_BITS_MEM_ADDR-1:0] o_mem_addr,
    input  logic [N_BITS_INSTR-1:0]    i_mem_data,
    output logic [N_BITS-1:0]          o_tx_data,
    output logic                       o_tx_start,
    input  logic                       i_tx_done,
    output logic                       o_busy,
    output logic                       o_dump_done,
    output logic [NB_STATE-1:0]        o_state
);

    localparam int MAX_ITEMS = (N_REGS > N_MEM_WORDS) ? N_REGS : N_MEM_WORDS;
    localparam int IDX_W     = (MAX_ITEMS > 1) ? $clog2(MAX_ITEMS) : 1;
    localparam logic [IDX_W-1:0] REG_LAST = IDX_W'(N_REGS - 1);
    localparam logic [IDX_W-1:0] MEM_LAST = IDX_W'(N_MEM_WORDS - 1);

    typedef enum logic [NB_STATE-1:0] {
        IDLE  = NB_STATE'(0),
        FETCH = NB_STATE'(1),
        LATCH = NB_STATE'(2),
        SEND  = NB_STATE'(3),
        WAIT  = NB_STATE'(4),
        DONE  = NB_STATE'(5)
    } state_e;

    typedef enum logic [1:0] {
        SEC_STATUS = 2'd0,
        SEC_PC     = 2'd1,
        SEC_REGS   = 2'd2,
        SEC_MEM    = 2'd3
    } section_e;

    state_e                     state_q,      state_d;
    section_e                   section_q,    section_d;
    logic [N_BITS_INSTR-1:0]    word_buf_q,   word_buf_d;
    logic [2:0]                 bytes_left_q, bytes_left_d;
    logic [IDX_W-1:0]           idx_q,        idx_d;
    logic [N_BITS_REG-1:0]      reg_addr_q,   reg_addr_d;
    logic [N_BITS_MEM_ADDR-1:0] mem_addr_q,   mem_addr_d;
    logic [IDX_W-1:0]           idx_next;

    assign idx_next = idx_q + 1'b1;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q      <= IDLE;
            section_q    <= SEC_STATUS;
            word_buf_q   <= '0;
            bytes_left_q <= '0;
            idx_q        <= '0;
            reg_addr_q   <= '0;
            mem_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            section_q    <= section_d;
            word_buf_q   <= word_buf_d;
            bytes_left_q <= bytes_left_d;
            idx_q        <= idx_d;
            reg_addr_q   <= reg_addr_d;
            mem_addr_q   <= mem_addr_d;
        end
    end

    // The read address moves on the WAIT->FETCH edge, so a synchronous-read
    // RAM has its data ready by the time LATCH samples it.
    always_comb begin
        state_d      = state_q;
        section_d    = section_q;
        word_buf_d   = word_buf_q;
        bytes_left_d = bytes_left_q;
        idx_d        = idx_q;
        reg_addr_d   = reg_addr_q;
        mem_addr_d   = mem_addr_q;

        case (state_q)
            IDLE: begin
                if (i_dump_request) begin
                    word_buf_d   = {{(N_BITS-1){1'b0}}, i_program_done,
                                    {(N_BITS_INSTR-N_BITS){1'b0}}};
                    section_d    = SEC_STATUS;
                    bytes_left_d = 3'd1;
                    idx_d        = '0;
                    state_d      = SEND;
                end
            end
            SEND: state_d = WAIT;
            WAIT: begin
                if (i_tx_done) begin
                    word_buf_d   = word_buf_q << N_BITS;
                    bytes_left_d = bytes_left_q - 3'd1;
                    state_d      = FETCH;
                    if (bytes_left_q != 3'd1) begin
                        state_d = SEND;
                    end else begin
                        case (section_q)
                            SEC_STATUS: section_d = SEC_PC;
                            SEC_PC: begin
                                section_d  = SEC_REGS;
                                idx_d      = '0;
                                reg_addr_d = '0;
                            end
                            SEC_REGS: begin
                                if (idx_q == REG_LAST) begin
                                    section_d  = SEC_MEM;
                                    idx_d      = '0;
                                    mem_addr_d = '0;
                                end else begin
                                    idx_d      = idx_next;
                                    reg_addr_d = N_BITS_REG'(idx_next);
                                end
                            end
                            default: begin
                                if (idx_q == MEM_LAST) begin
                                    state_d = DONE;
                                end else begin
                                    idx_d      = idx_next;
                                    mem_addr_d = N_BITS_MEM_ADDR'(idx_next);
                                end
                            end
                        endcase
                    end
                end
            end
            FETCH: state_d = LATCH;
            LATCH: begin
                case (section_q)
                    SEC_REGS: word_buf_d = i_reg_data;
                    SEC_MEM:  word_buf_d = i_mem_data;
                    default:  word_buf_d = i_pc;
                endcase
                bytes_left_d = 3'd4;
                state_d      = SEND;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign o_tx_data   = word_buf_q[N_BITS_INSTR-1 -: N_BITS];
    assign o_tx_start  = (state_q == SEND);
    assign o_busy      = (state_q != IDLE);
    assign o_dump_done = (state_q == DONE);
    assign o_state     = state_q;
    assign o_reg_addr  = reg_addr_q;
    assign o_mem_addr  = mem_addr_q;

endmodule

// File: tb/tb_debug_unit_dump_ctrl.sv
// Bench for debug_unit_dump_ctrl: frame scenarios from a vector table against
// a byte-stream reference model, plus reset, async-reset and small-variant cases.
module tb_debug_unit_dump_ctrl;

    localparam int NR = 32;
    localparam int NM = 32;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // main instance
    logic        req_task, req_mon, dump_req;
    logic        program_done;
    logic [31:0] pc, reg_data, mem_data;
    logic [4:0]  reg_addr, mem_addr;
    logic [7:0]  tx_data;
    logic        tx_start, resp_done, spur_done, tx_done, busy, dump_done;
    logic [2:0]  state;
    logic [31:0] regs [NR];
    logic [31:0] mems [NM];

    assign dump_req = req_task | req_mon;
    assign tx_done  = resp_done | spur_done;

    debug_unit_dump_ctrl dut (
        .i_clock(clk), .i_reset(rst_n), .i_dump_request(dump_req),
        .i_program_done(program_done), .i_pc(pc),
        .o_reg_addr(reg_addr), .i_reg_data(reg_data),
        .o_mem_addr(mem_addr), .i_mem_data(mem_data),
        .o_tx_data(tx_data), .o_tx_start(tx_start), .i_tx_done(tx_done),
        .o_busy(busy), .o_dump_done(dump_done), .o_state(state)
    );

    always @(posedge clk) begin
        reg_data <= regs[reg_addr];
        mem_data <= mems[mem_addr];
    end

    // small variant instance
    logic        v_req, v_pd;
    logic [31:0] v_pc, v_reg_data, v_mem_data;
    logic [4:0]  v_reg_addr, v_mem_addr;
    logic [7:0]  v_tx_data;
    logic        v_tx_start, v_tx_done, v_busy, v_dump_done;
    logic [2:0]  v_state;
    logic [31:0] v_regs [2];
    logic [31:0] v_mem0;

    debug_unit_dump_ctrl #(.N_REGS(2), .N_MEM_WORDS(1)) dut_v (
        .i_clock(clk), .i_reset(rst_n), .i_dump_request(v_req),
        .i_program_done(v_pd), .i_pc(v_pc),
        .o_reg_addr(v_reg_addr), .i_reg_data(v_reg_data),
        .o_mem_addr(v_mem_addr), .i_mem_data(v_mem_data),
        .o_tx_data(v_tx_data), .o_tx_start(v_tx_start), .i_tx_done(v_tx_done),
        .o_busy(v_busy), .o_dump_done(v_dump_done), .o_state(v_state)
    );

    always @(posedge clk) begin
        v_reg_data <= v_regs[v_reg_addr[0]];
        v_mem_data <= v_mem0;
    end

    // monitors / UART TX responders
    logic [7:0] cap_q[$];
    int         st_q[$];
    int         pend = 0, cur_delay = 1, dd_cnt = 0, dd_cyc = 0, overlap = 0;
    bit         busy_en = 0, spur_en = 0;

    logic [7:0] v_cap[$];
    int         v_ra[$], v_ma[$];
    int         v_pend = 0, v_dd_cnt = 0;

    initial begin
        resp_done = 0; spur_done = 0; req_mon = 0;
        forever begin
            @(negedge clk);
            resp_done = 0; spur_done = 0; req_mon = 0;
            if (!rst_n) begin
                pend = 0;
                spur_done = spur_en & ($urandom_range(0, 1) == 1);
            end else begin
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) resp_done = 1;
                end
                if (tx_start) begin
                    cap_q.push_back(tx_data);
                    st_q.push_back(cyc);
                    pend = cur_delay;
                    if (busy_en && cap_q.size() == 10) req_mon = 1;
                end
                if (busy_en && state == 3'd5) req_mon = 1;
                if (spur_en && (state == 3'd0 || state == 3'd1 || state == 3'd2)) spur_done = 1;
                if (dump_done) begin dd_cnt++; dd_cyc = cyc; end
            end
        end
    end

    initial begin
        v_tx_done = 0;
        forever begin
            @(negedge clk);
            v_tx_done = 0;
            if (!rst_n) v_pend = 0;
            else begin
                if (v_pend > 0) begin
                    v_pend--;
                    if (v_pend == 0) v_tx_done = 1;
                end
                if (v_tx_start) begin v_cap.push_back(v_tx_data); v_pend = 2; end
                if (v_state == 3'd2) begin v_ra.push_back(int'(v_reg_addr)); v_ma.push_back(int'(v_mem_addr)); end
                if (v_dump_done) v_dd_cnt++;
            end
        end
    end

    always @(posedge clk) if (tx_start && tx_done) overlap <= overlap + 1;

    // checking
    int errors = 0, checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // reference model: the frame is just the concatenation of the sections
    logic [7:0] exp_q[$];

    task automatic push_word(input logic [31:0] w);
        for (int b = 3; b >= 0; b--) exp_q.push_back(w[8*b +: 8]);
    endtask

    function automatic int count_bad(input logic [7:0] a[$], input logic [7:0] b[$]);
        int bad = (a.size() > b.size()) ? a.size() - b.size() : b.size() - a.size();
        int n   = (a.size() < b.size()) ? a.size() : b.size();
        for (int k = 0; k < n; k++) if (a[k] !== b[k]) bad++;
        return bad;
    endfunction

    typedef struct {
        bit         pd;
        bit         fixed_data;
        int         delay;
        bit         busy;
        bit         spur;
        int         exp_len;
        logic [7:0] exp_status;
        int         exp_gap_w;
        int         exp_gap_i;
    } vec_t;

    vec_t vecs[5];

    task automatic run_frame(input vec_t v, input int id);
        logic [31:0] pcv;
        int req_cyc, bad_gaps, ln;
        string tag;
        tag = $sformatf("frame%0d", id);
        for (int i = 0; i < NR; i++) regs[i] = v.fixed_data ? 32'h01010101 * i : $urandom;
        for (int j = 0; j < NM; j++) mems[j] = v.fixed_data ? 32'hA0000000 + j : $urandom;
        pcv = v.fixed_data ? 32'h00000040 : $urandom;
        exp_q.delete();
        exp_q.push_back({7'b0, v.pd});
        push_word(pcv);
        for (int i = 0; i < NR; i++) push_word(regs[i]);
        for (int j = 0; j < NM; j++) push_word(mems[j]);
        cap_q.delete(); st_q.delete(); dd_cnt = 0; overlap = 0;
        cur_delay = v.delay; busy_en = v.busy; spur_en = v.spur;
        pc = pcv; program_done = v.pd;
        @(negedge clk);
        req_task = 1; req_cyc = cyc;
        @(negedge clk);
        req_task = 0;
        program_done = ~v.pd;
        for (int c = 0; c < 6000 && dd_cnt == 0; c++) @(negedge clk);
        repeat (8) @(negedge clk);
        busy_en = 0; spur_en = 0;
        ln = cap_q.size();
        check({tag, "_len"}, ln, v.exp_len);
        check({tag, "_status"}, (ln > 0) ? cap_q[0] : 8'hxx, v.exp_status);
        check({tag, "_bytes_bad"}, count_bad(cap_q, exp_q), 0);
        check({tag, "_first_lat"}, (ln > 0) ? st_q[0] - req_cyc : -1, 1);
        bad_gaps = 0;
        for (int k = 1; k < ln; k++)
            if (st_q[k] - st_q[k-1] != (((k - 1) % 4 == 0) ? v.exp_gap_i : v.exp_gap_w)) bad_gaps++;
        check({tag, "_gaps_bad"}, bad_gaps, 0);
        check({tag, "_dump_done_cnt"}, dd_cnt, 1);
        check({tag, "_dump_done_cyc"}, dd_cyc, (ln > 0) ? st_q[ln-1] + v.delay + 1 : -1);
        check({tag, "_idle_after"}, {busy, state}, 4'b0000);
        check({tag, "_start_done_overlap"}, overlap, 0);
    endtask

    initial begin
        bit found;
        vecs[0] = '{1, 1, 5, 0, 0, 261, 8'h01, 6, 8};
        vecs[1] = '{0, 0, 1, 0, 0, 261, 8'h00, 2, 4};
        vecs[2] = '{1, 0, 3, 1, 0, 261, 8'h01, 4, 6};
        vecs[3] = '{0, 0, 2, 0, 1, 261, 8'h00, 3, 5};
        vecs[4] = '{1, 0, 1, 1, 1, 261, 8'h01, 2, 4};

        req_task = 0; program_done = 0; pc = 0;
        v_req = 0; v_pd = 0; v_pc = 0; v_mem0 = 0;
        for (int i = 0; i < NR; i++) regs[i] = 0;
        for (int j = 0; j < NM; j++) mems[j] = 0;
        v_regs[0] = 0; v_regs[1] = 0;

        // reset held low with inputs toggling
        rst_n = 0; spur_en = 1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            req_task = 1'($urandom); program_done = 1'($urandom); pc = $urandom;
            for (int i = 0; i < NR; i++) regs[i] = $urandom;
        end
        #1;
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_busy", busy, 0);
        check("rst_dump_done", dump_done, 0);
        check("rst_state", state, 0);
        check("rst_reg_addr", reg_addr, 0);
        check("rst_mem_addr", mem_addr, 0);
        @(negedge clk);
        req_task = 0; spur_en = 0; rst_n = 1;
        repeat (2) @(negedge clk);

        // asynchronous reset mid-SEND
        cap_q.delete(); cur_delay = 2; program_done = 1;
        req_task = 1;
        @(negedge clk);
        req_task = 0;
        found = 0;
        for (int c = 0; c < 200 && !found; c++) begin
            @(negedge clk);
            if (tx_start && cap_q.size() >= 3) found = 1;
        end
        check("async_send_reached", found, 1);
        #2 rst_n = 0;
        #1;
        check("async_tx_start", tx_start, 0);
        check("async_state", state, 0);
        check("async_busy", busy, 0);
        check("async_tx_data", tx_data, 0);
        @(negedge clk);
        rst_n = 1;
        repeat (3) @(negedge clk);

        for (int t = 0; t < 5; t++) run_frame(vecs[t], t);

        // N_REGS=2, N_MEM_WORDS=1 variant, program_done low
        v_regs[0] = $urandom; v_regs[1] = $urandom; v_mem0 = $urandom; v_pc = $urandom;
        exp_q.delete();
        exp_q.push_back(8'h00);
        push_word(v_pc); push_word(v_regs[0]); push_word(v_regs[1]); push_word(v_mem0);
        v_cap.delete(); v_ra.delete(); v_ma.delete(); v_dd_cnt = 0;
        @(negedge clk);
        v_req = 1;
        @(negedge clk);
        v_req = 0;
        for (int c = 0; c < 500 && v_dd_cnt == 0; c++) @(negedge clk);
        repeat (5) @(negedge clk);
        check("var_len", v_cap.size(), 17);
        check("var_bytes_bad", count_bad(v_cap, exp_q), 0);
        check("var_status", (v_cap.size() > 0) ? v_cap[0] : 8'hxx, 8'h00);
        check("var_latch_cnt", v_ra.size(), 4);
        check("var_reg_addr0", (v_ra.size() > 1) ? v_ra[1] : -1, 0);
        check("var_reg_addr1", (v_ra.size() > 2) ? v_ra[2] : -1, 1);
        check("var_mem_addr0", (v_ma.size() > 3) ? v_ma[3] : -1, 0);
        check("var_dump_done_cnt", v_dd_cnt, 1);
        check("var_idle_after", {v_busy, v_state}, 4'b0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/debug_unit_dump_ctrl.md
Name: debug_unit_dump_ctrl

Overview:
Sequences the post-step / post-halt state dump of the MIPS debug unit over the UART transmitter. On a dump request it emits one frame over the UART: a status byte, then the PC, then every register-file word, then the first N_MEM_WORDS data-memory words. Each 32-bit word is sent MSB byte first. It owns the debug read ports of the register file and data memory and the UART TX start/done handshake. It sits beside the debug receive path, between the pipeline and the UART TX.

Parameters:
N_BITS, 8, UART byte width
N_BITS_INSTR, 32, datapath word width
N_BITS_REG, 5, register-file address width
N_REGS, 32, registers dumped (indices 0..N_REGS-1)
N_BITS_MEM_ADDR, 5, data-memory word address width
N_MEM_WORDS, 32, memory words dumped (addresses 0..N_MEM_WORDS-1)
NB_STATE, 3, state encoding width

Ports:
i_clock  in  1  single clock; all flops on rising edge
i_reset  in  1  asynchronous, active-low reset
i_dump_request  in  1  start pulse (step completed or halt reached)
i_program_done  in  1  level; halt reached, sampled into the status byte
i_pc  in  N_BITS_INSTR  current PC
o_reg_addr  out  N_BITS_REG  register-file debug read address
i_reg_data  in  N_BITS_INSTR  register data, valid the cycle after o_reg_addr changes
o_mem_addr  out  N_BITS_MEM_ADDR  data-memory debug read address
i_mem_data  in  N_BITS_INSTR  memory data, valid the cycle after o_mem_addr changes
o_tx_data  out  N_BITS  byte to transmit
o_tx_start  out  1  one-cycle TX start strobe
i_tx_done  in  1  one-cycle strobe from UART TX: byte finished
o_busy  out  1  high from request acceptance until DONE exits
o_dump_done  out  1  one-cycle pulse at end of frame
o_state  out  NB_STATE  current state (debug)

Behaviour:
- Reset (i_reset=0, async): state=IDLE. All outputs 0. Word buffer, byte index, item index and section cleared. Effect is immediate, including mid-frame; o_tx_start drops without waiting for a clock.
- States: IDLE=000, FETCH=001, LATCH=010, SEND=011, WAIT=100, DONE=101. Other codes go to IDLE on the next clock.
- Sections, in order: STATUS (1 byte), PC (4 bytes), REGS (N_REGS words x 4 bytes), MEM (N_MEM_WORDS words x 4 bytes). Frame length = 5 + 4*(N_REGS+N_MEM_WORDS) bytes; default 261.
- IDLE: o_busy=0. When i_dump_request=1 at a clock edge:
  - word_buf[31:24] <= {7'b0, i_program_done}; section=STATUS; bytes_left=1; go SEND.
  - o_tx_start is therefore high in the cycle immediately after the request edge (1-cycle latency).
- SEND: o_tx_data=word_buf[31:24]; o_tx_start=1 for exactly this one cycle; next state WAIT unconditionally.
- WAIT: hold o_tx_data. On i_tx_done=1: shift word_buf left by 8 and decrement bytes_left. Then:
  - bytes_left still >0: go SEND.
  - otherwise advance the item:
    - STATUS -> PC.
    - PC -> REGS index 0.
    - REGS index k<N_REGS-1 -> k+1.
    - REGS last -> MEM index 0.
    - MEM index k<N_MEM_WORDS-1 -> k+1.
    - MEM last -> DONE.
  - Every transition other than DONE goes to FETCH.
- FETCH: drive o_reg_addr (REGS) or o_mem_addr (MEM) with the item index. The address is registered and held until the next item. Next state LATCH.
- LATCH: word_buf <= i_pc / i_reg_data / i_mem_data per section; bytes_left=4; go SEND.
  - Item-to-item gap is therefore 3 cycles after i_tx_done (FETCH, LATCH, SEND).
- DONE: o_dump_done=1 for one cycle; o_busy=1; next IDLE. Addresses keep their last values.
- o_busy=1 in every state except IDLE.
- o_tx_start never coincides with i_tx_done and is never re-asserted before the matching i_tx_done.
- i_dump_request while busy: ignored, not queued. A request in the DONE cycle is also ignored.
- i_tx_done outside WAIT: ignored; no state, counter or buffer change.
- i_program_done is sampled only at request acceptance; later changes do not alter the frame.
- Counters are sized to hold max(N_REGS, N_MEM_WORDS)-1 without overflow. No wrap-around within a frame.

Test Plan:
- Reset values: hold i_reset=0, toggle all inputs -> every output 0, o_state=000. Assert i_reset=0 asynchronously mid-cycle during SEND -> o_tx_start falls before the next edge.
- Full frame: reg[i]=0x01010101*i, mem[j]=0xA0000000+j, pc=0x00000040, program_done=1, TX model returns i_tx_done 5 cycles after each start. Required:
  - exactly 261 starts;
  - bytes in order 01, 00 00 00 40, reg0..reg31 MSB first, mem0..mem31 MSB first;
  - o_dump_done pulses once, 1 cycle after the final i_tx_done lands in DONE.
- Latency/gaps: with i_tx_done returning immediately (the cycle after start):
  - first start 1 cycle after the request;
  - within a word, start 2 cycles after the previous start;
  - between items, 4 cycles after the previous start.
- Request while busy: pulse i_dump_request at byte 10 and in the DONE cycle -> still exactly one 261-byte frame, single o_dump_done, then IDLE.
- Spurious i_tx_done: pulse it in IDLE and in FETCH/LATCH -> no byte skipped, frame content unchanged.
- Parameter variant N_REGS=2, N_MEM_WORDS=1 -> 17-byte frame; o_reg_addr sequence 0,1; o_mem_addr 0; status byte 00 when program_done=0.
